// File: rtl/timer_event_fifo.sv
// timer_event_fifo: tags rising edges of event_in with a free-running 32-bit
// cycle count and queues them. The CPU drains the queue through a 16-bit
// Avalon-MM slave. It pops into a 32-bit hold register, then reads HOLD_L and
// HOLD_H.
module timer_event_fifo #(
  parameter int          DEPTH    = 16,
  // Value loaded into the timestamp counter by reset (0 in normal use).
  parameter logic [31:0] TS_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        event_in,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_POP     = 3'd2;
  localparam logic [2:0] ADDR_HOLD_L  = 3'd3;
  localparam logic [2:0] ADDR_HOLD_H  = 3'd4;

  logic [31:0]   ts_q, ts_d;
  logic          event_d_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   hold_q, hold_d;
  logic          capture_en_q, capture_en_d;
  logic          irq_en_q, irq_en_d;
  logic [15:0]   readdata_q, readdata_d;

  logic wr, ev_edge, flush, pop_req;
  logic empty, full;
  logic do_push, do_pop, drop;

  // Only writedata[2:0] carry meaning; the upper bits are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata[15:3];

  // Decode bus strobes and resolve push/pop/drop for this cycle.
  always_comb begin
    wr      = chipselect & ~write_n;
    ev_edge = event_in & ~event_d_q & capture_en_q;
    flush   = wr && (address == ADDR_CONTROL) && writedata[2];
    pop_req = wr && (address == ADDR_POP);
    empty   = (count_q == '0);
    full    = (count_q == FULL_COUNT);
    // A pop frees a slot in the same cycle, so an edge on a full queue
    // still lands if it coincides with a pop; flush overrides both.
    do_pop  = pop_req & ~empty & ~flush;
    do_push = ev_edge & ~flush & (~full | do_pop);
    drop    = ev_edge & ~flush & full & ~do_pop;
  end

  // Next-state for counter, pointers, count, flags, hold and control.
  always_comb begin
    ts_d         = ts_q + 32'd1;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    hold_d       = hold_q;
    capture_en_d = capture_en_q;
    irq_en_d     = irq_en_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Set wins over clear so a drop in the clearing cycle is not lost.
    if (wr && (address == ADDR_STATUS)) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;

    if (wr && (address == ADDR_CONTROL)) begin
      capture_en_d = writedata[0];
      irq_en_d     = writedata[1];
    end
  end

  // Read mux, registered every cycle for one-cycle read latency.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS:  readdata_d = {8'(count_q), 5'b0, overflow_q, full, ~empty};
      ADDR_CONTROL: readdata_d = {14'b0, irq_en_q, capture_en_q};
      ADDR_HOLD_L:  readdata_d = hold_q[15:0];
      ADDR_HOLD_H:  readdata_d = hold_q[31:16];
      default:      readdata_d = '0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q         <= TS_RESET;
      event_d_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      hold_q       <= '0;
      capture_en_q <= 1'b0;
      irq_en_q     <= 1'b0;
      readdata_q   <= '0;
    end else begin
      ts_q         <= ts_d;
      event_d_q    <= event_in;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      hold_q       <= hold_d;
      capture_en_q <= capture_en_d;
      irq_en_q     <= irq_en_d;
      readdata_q   <= readdata_d;
    end
  end

  // Queue storage; contents past the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= ts_q;
  end

  assign readdata = readdata_q;
  assign irq      = ~empty & irq_en_q;

endmodule

// File: tb/tb_timer_event_fifo.sv
// Testbench for timer_event_fifo: a register-access vector table plus
// directed sequences for timestamps, overflow, full+pop, wrap, flush, reset.
module tb_timer_event_fifo;

  logic        clk = 1'b0;
  logic        reset, event_in, chipselect, write_n;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata, readdata_w;
  logic        irq, irq_w;

  always #5 clk = ~clk;

  timer_event_fifo #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .chipselect(chipselect),
    .address(address), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  // Second instance starts its timestamp just below the 32-bit wrap.
  timer_event_fifo #(.DEPTH(16), .TS_RESET(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .event_in(event_in), .chipselect(chipselect),
    .address(address), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_w), .irq(irq_w)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] tb_ts;
  logic [15:0] rd, rdw;
  logic [31:0] q[$];
  logic [31:0] t;

  // Reference cycle count: equals the timestamp an edge driven now captures.
  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
    logic        ev;
    logic [15:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl [37];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [2:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    rd  = readdata;
    rdw = readdata_w;
    idle();
  endtask

  task automatic pulse(output logic [31:0] ts);
    ts = tb_ts;
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
  endtask

  task automatic wait_ts(input logic [31:0] target);
    int unsigned n = 0;
    while (tb_ts != target && n < 1000) begin
      tick();
      n++;
    end
    if (tb_ts != target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ts: timestamp %0d never reached (at %0d)", target, tb_ts);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd3);
    check({name, "_L"}, 32'(rd), 32'(exp[15:0]));
    bus_read(3'd4);
    check({name, "_H"}, 32'(rd), 32'(exp[31:16]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    event_in = 1'b0;
    idle();

    // Register-access table; vector i drives its event at timestamp i.
    tbl = '{
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 0 reset STATUS
      '{1'b1, 3'd1, 16'h0003, 1'b0, 16'h0000, 1'b0},  // 1 CONTROL=3
      '{1'b0, 3'd1, 16'h0000, 1'b0, 16'h0003, 1'b0},  // 2
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b1},  // 3 edge ts=3
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0101, 1'b1},  // 4 level, no edge
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0101, 1'b1},  // 5
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0101, 1'b1},  // 6 edge ts=6
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0201, 1'b1},  // 7
      '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b1},  // 8 pop
      '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h0003, 1'b1},  // 9
      '{1'b0, 3'd4, 16'h0000, 1'b0, 16'h0000, 1'b1},  // 10
      '{1'b1, 3'd1, 16'h0001, 1'b0, 16'h0003, 1'b0},  // 11 irq_en off
      '{1'b0, 3'd1, 16'h0000, 1'b0, 16'h0001, 1'b0},  // 12
      '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 13 pop
      '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h0006, 1'b0},  // 14
      '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 15 pop empty
      '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h0006, 1'b0},  // 16 hold kept
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 17
      '{1'b1, 3'd6, 16'hFFFF, 1'b0, 16'h0000, 1'b0},  // 18 unmapped write
      '{1'b0, 3'd1, 16'h0000, 1'b0, 16'h0001, 1'b0},  // 19
      '{1'b0, 3'd7, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 20
      '{1'b1, 3'd1, 16'h0000, 1'b1, 16'h0001, 1'b0},  // 21 disable + edge
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0101, 1'b0},  // 22
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0101, 1'b0},  // 23 edge ignored
      '{1'b1, 3'd1, 16'h0001, 1'b1, 16'h0000, 1'b0},  // 24 enable, level
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0101, 1'b0},  // 25 still one
      '{1'b1, 3'd1, 16'h0007, 1'b0, 16'h0001, 1'b0},  // 26 flush
      '{1'b0, 3'd1, 16'h0000, 1'b0, 16'h0003, 1'b0},  // 27
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 28
      '{1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b1},  // 29 edge ts=29
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0101, 1'b1},  // 30
      '{1'b1, 3'd2, 16'h0000, 1'b1, 16'h0000, 1'b1},  // 31 pop + edge
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0101, 1'b1},  // 32 count kept
      '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h001D, 1'b1},  // 33
      '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0},  // 34 pop
      '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h001F, 1'b0},  // 35
      '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0}   // 36
    };

    do_reset();
    for (int i = 0; i < 37; i++) begin
      chipselect = 1'b1;
      write_n    = ~tbl[i].wr;
      address    = tbl[i].a;
      writedata  = tbl[i].d;
      event_in   = tbl[i].ev;
      tick();
      check($sformatf("tbl%0d_rd", i), 32'(readdata), 32'(tbl[i].rd));
      check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
    end
    idle();
    event_in = 1'b0;

    // Timestamps 100 and 250.
    do_reset();
    bus_write(3'd1, 16'h0003);
    wait_ts(32'd100);
    pulse(t);
    wait_ts(32'd250);
    pulse(t);
    bus_read(3'd0);
    check("basic_status", 32'(rd), 32'h0201);
    check("basic_irq1", 32'(irq), 32'd1);
    pop_check("basic_pop0", 32'h0000_0064);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd3);
    check("basic_pop1_L", 32'(rd), 32'h00FA);
    bus_read(3'd0);
    check("basic_status_empty", 32'(rd), 32'h0000);
    check("basic_irq0", 32'(irq), 32'd0);

    // Long level -> one entry; level through reset release -> none.
    do_reset();
    bus_write(3'd1, 16'h0001);
    event_in = 1'b1;
    repeat (50) tick();
    event_in = 1'b0;
    tick();
    bus_read(3'd0);
    check("level_one_entry", 32'(rd), 32'h0101);
    event_in = 1'b1;
    do_reset();
    bus_write(3'd1, 16'h0001);
    repeat (5) tick();
    bus_read(3'd0);
    check("level_at_reset", 32'(rd), 32'h0000);
    event_in = 1'b0;

    // 17 edges into 16 entries; clear racing a drop keeps overflow.
    do_reset();
    bus_write(3'd1, 16'h0001);
    q.delete();
    for (int i = 0; i < 17; i++) begin
      pulse(t);
      if (i < 16) q.push_back(t);
    end
    bus_read(3'd0);
    check("ovf_status", 32'(rd), 32'h1007);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; event_in = 1'b1;
    tick();
    idle(); event_in = 1'b0;
    tick();
    bus_read(3'd0);
    check("ovf_clear_vs_drop", 32'(rd), 32'h1007);
    bus_write(3'd0, 16'h0000);
    bus_read(3'd0);
    check("ovf_cleared", 32'(rd), 32'h1003);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_pop%0d", i), q[i]);
    bus_read(3'd0);
    check("ovf_drained", 32'(rd), 32'h0000);

    // Full queue, edge and pop in the same cycle.
    do_reset();
    bus_write(3'd1, 16'h0001);
    q.delete();
    for (int i = 0; i < 16; i++) begin
      pulse(t);
      q.push_back(t);
    end
    bus_read(3'd0);
    check("full_status", 32'(rd), 32'h1003);
    t = tb_ts;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd2; event_in = 1'b1;
    tick();
    idle(); event_in = 1'b0;
    tick();
    q.push_back(t);
    bus_read(3'd0);
    check("full_pop_push_status", 32'(rd), 32'h1003);
    bus_read(3'd3);
    check("full_hold_oldest", 32'(rd), 32'(q[0][15:0]));
    void'(q.pop_front());
    for (int i = 0; i < 16; i++) pop_check($sformatf("full_pop%0d", i), q[i]);
    bus_read(3'd0);
    check("full_drained", 32'(rd), 32'h0000);

    // Timestamp wrap on the offset instance.
    do_reset();
    bus_write(3'd1, 16'h0001);
    wait_ts(32'd2);
    pulse(t);
    wait_ts(32'd5);
    pulse(t);
    bus_read(3'd0);
    check("wrap_status", 32'(rdw), 32'h0201);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd3);
    check("wrap0_L", 32'(rdw), 32'hFFFE);
    bus_read(3'd4);
    check("wrap0_H", 32'(rdw), 32'hFFFF);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd3);
    check("wrap1_L", 32'(rdw), 32'h0001);
    bus_read(3'd4);
    check("wrap1_H", 32'(rdw), 32'h0000);

    // Flush with a simultaneous edge, pop on empty, then reset mid-stream.
    do_reset();
    bus_write(3'd1, 16'h0003);
    q.delete();
    for (int i = 0; i < 6; i++) begin
      pulse(t);
      q.push_back(t);
    end
    bus_write(3'd2, 16'h0000);
    bus_read(3'd0);
    check("flush_pre_status", 32'(rd), 32'h0501);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h0007;
    event_in = 1'b1;
    tick();
    idle(); event_in = 1'b0;
    check("flush_irq", 32'(irq), 32'd0);
    tick();
    bus_read(3'd0);
    check("flush_status", 32'(rd), 32'h0000);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd3);
    check("empty_pop_hold", 32'(rd), 32'(q[0][15:0]));
    pulse(t);
    pulse(t);
    bus_write(3'd2, 16'h0000);
    do_reset();
    check("rst_readdata", 32'(readdata), 32'h0000);
    check("rst_irq", 32'(irq), 32'd0);
    bus_read(3'd0);
    check("rst_status", 32'(rd), 32'h0000);
    bus_read(3'd1);
    check("rst_control", 32'(rd), 32'h0000);
    bus_read(3'd3);
    check("rst_hold_l", 32'(rd), 32'h0000);
    bus_read(3'd4);
    check("rst_hold_h", 32'(rd), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
